fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Sequencer for the dual-slot fetch PC datapath (pcF1/pcF2 next-PC unit).
- Collects redirect requests from the execute stage (conditional branch, jalr) and the decode stage (jal), plus front-end stall requests.
- Selects one redirect per cycle, registers the selected request and drives the datapath's PCSrc select, hold enable and immediate operands.
- Kills wrong-path fetches for a programmable number of cycles after each redirect.

Parameters:
- FLUSH_CYCLES, 2: number of cycles after an issued redirect during which requests are ignored and flush_f is held high; legal range 1..15.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  front-end stall (icache miss, decode backpressure).
- br_req_i  in  1  execute stage: taken conditional branch.
- br_imm_i  in  12  branch offset, unshifted.
- jalr_req_i  in  1  execute stage: jalr.
- jalr_tgt_i  in  32  absolute jalr target.
- jal_req_i  in  1  decode stage: jal.
- jal_imm_i  in  20  jal offset, unshifted.
- pc_src_o  out  2  to datapath PCSrc: 00 sequential, 01 branch, 10 jal, 11 jalr.
- pc_hold_o  out  1  to datapath EN; 1 freezes pcF1/pcF2.
- imm_o  out  12  to datapath branch immediate.
- imm_jal_o  out  20  to datapath jal immediate.
- imm_jalr_o  out  32  to datapath jalr target.
- flush_f_o  out  1  invalidate the fetched pair this cycle.
- busy_o  out  1  a redirect is pending or flushing.
- conflict_o  out  1  sticky: br_req_i and jalr_req_i were asserted in the same cycle.
- redirect_cnt_o  out  CNT_W  redirects issued (optional feature).
- stall_cnt_o  out  CNT_W  stalled cycles (optional feature).

Behaviour:
Reset values (rst=1 at a clock edge):
- State is RUN.
- pc_src_o=00, pc_hold_o=1 for the reset cycle only, all immediate outputs 0.
- flush_f_o=0, busy_o=0, conflict_o=0, counters 0.
- Reset asserted mid-operation discards any pending redirect and any flush countdown.

Request priority, oldest instruction first: br > jalr > jal.
- br and jalr both asserted: br wins and conflict_o is set. conflict_o is cleared only by rst.

States:
- RUN:
  - No request and stall_i=0: pc_src_o=00, pc_hold_o=0.
  - stall_i=1: pc_hold_o=1, pc_src_o=00.
  - Request accepted in cycle N: the winning source and operands are captured into the pending register. If stall_i=0, go to ISSUE; otherwise go to PEND.
- PEND:
  - pc_hold_o=1, busy_o=1.
  - A new br or jalr request overwrites the pending entry, because it is from an older instruction.
  - A jal request never overwrites a pending br or jalr; it overwrites only a pending jal.
  - stall_i=0 at a clock edge: go to ISSUE.
- ISSUE (exactly one cycle):
  - pc_src_o = pending source code and pc_hold_o=0, regardless of stall_i. The datapath loads the new PC at the end of this cycle.
  - Immediate outputs are driven from the pending register.
  - flush_f_o=1.
  - Flush counter loads FLUSH_CYCLES-1; go to FLUSH, or to RUN when FLUSH_CYCLES=1.
- FLUSH:
  - flush_f_o=1, busy_o=1.
  - All redirect requests are ignored as wrong-path.
  - pc_hold_o follows stall_i; pc_src_o=00.
  - The counter decrements each cycle; go to RUN when it reaches 0.
- End-to-end latency: a request accepted at edge N with no stall causes a PC update at edge N+1.
- Immediate outputs are registered and hold their last issued values outside ISSUE.
- Arithmetic: target arithmetic is done in the datapath; this block performs no arithmetic. The only arithmetic is the flush countdown and the counters, which wrap modulo 2^CNT_W.

Optional Feature:
Macro FETCH_REDIRECT_PERF_EN.
- Defined:
  - redirect_cnt_o increments on every ISSUE cycle.
  - stall_cnt_o increments on every cycle with pc_hold_o=1 outside reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. Port list is unchanged.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - PCSRC_SEQ=00, PCSRC_BR=01, PCSRC_JAL=10, PCSRC_JALR=11.
  - State encoding: RUN, PEND, ISSUE, FLUSH.
  - Pending-entry record: source code plus 12/20/32-bit operands.
- One sub-module: redirect_prio_enc. It is combinational and takes the three requests plus the pending source. It outputs the winner, the overwrite enable and the conflict pulse.

Test Plan:
- Reset sequence: rst=1 for 2 cycles, then 0 -> pc_hold_o=1 only while rst=1; thereafter pc_src_o=00, pc_hold_o=0 and all other outputs 0.
- Branch with no stall: br_req_i=1, br_imm_i=12'h010 at edge N -> cycle N+1 shows pc_src_o=01, imm_o=12'h010, pc_hold_o=0, flush_f_o=1. flush_f_o stays high for exactly 2 cycles; a jal_req_i during that window is ignored.
- Redirect under stall: stall_i=1; jal_req_i=1 with jal_imm_i=20'h00100, then jalr_req_i=1 with jalr_tgt_i=32'h0001_0040 two cycles later -> pc_hold_o=1 throughout. After stall_i drops: one ISSUE cycle with pc_src_o=11 and imm_jalr_o=32'h0001_0040; the jal is lost.
- Conflict: br_req_i=1 and jalr_req_i=1 in the same cycle -> pc_src_o=01 issued, conflict_o=1 and it stays 1 until rst.
- Reset in PEND: assert rst while in PEND -> next cycle busy_o=0, no ISSUE ever occurs and pc_src_o=00.
- Performance counters (FETCH_REDIRECT_PERF_EN defined): 3 redirects and 5 stall cycles -> redirect_cnt_o=3 and stall_cnt_o=5. With the macro undefined, both read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch redirect sequencer: PCSrc codes, FSM states, pending record.
package fetch_ctrl_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JAL  = 2'b10;
  localparam logic [1:0] PCSRC_JALR = 2'b11;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]  src;
    logic [11:0] imm;
    logic [19:0] imm_jal;
    logic [31:0] jalr_tgt;
  } pend_t;

endpackage

// File: rtl/redirect_prio_enc.sv
// Combinational redirect arbiter: oldest instruction wins (br > jalr > jal).
// A jal may only replace an empty or jal pending slot.
module redirect_prio_enc
  import fetch_ctrl_pkg::*;
(
  input  logic       i_br_req,
  input  logic       i_jalr_req,
  input  logic       i_jal_req,
  input  logic [1:0] i_pend_src,
  output logic [1:0] o_winner,
  output logic       o_we,
  output logic       o_conflict
);

  logic w_jal_may_write;

  assign w_jal_may_write = (i_pend_src == PCSRC_SEQ) || (i_pend_src == PCSRC_JAL);

  always_comb begin
    o_winner = PCSRC_SEQ;
    if (i_br_req)        o_winner = PCSRC_BR;
    else if (i_jalr_req) o_winner = PCSRC_JALR;
    else if (i_jal_req)  o_winner = PCSRC_JAL;
  end

  assign o_we       = i_br_req | i_jalr_req | (i_jal_req & w_jal_may_write);
  assign o_conflict = i_br_req & i_jalr_req;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer driving the dual-slot PC datapath (PCSrc, hold, immediates, flush).
// Optional perf counters enabled by FETCH_REDIRECT_PERF_EN.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_req_i,
  input  logic [11:0]      br_imm_i,
  input  logic             jalr_req_i,
  input  logic [31:0]      jalr_tgt_i,
  input  logic             jal_req_i,
  input  logic [19:0]      jal_imm_i,
  output logic [1:0]       pc_src_o,
  output logic             pc_hold_o,
  output logic [11:0]      imm_o,
  output logic [19:0]      imm_jal_o,
  output logic [31:0]      imm_jalr_o,
  output logic             flush_f_o,
  output logic             busy_o,
  output logic             conflict_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 r_state;
  pend_t                  r_pend;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [1:0]             r_pc_src;
  logic [11:0]            r_imm;
  logic [19:0]            r_imm_jal;
  logic [31:0]            r_imm_jalr;
  logic                   r_flush;
  logic                   r_busy;
  logic                   r_conflict;

  logic       w_accept;
  logic [1:0] w_pend_src;
  logic [1:0] w_winner;
  logic       w_we;
  logic       w_conflict;
  pend_t      w_pend_new;
  pend_t      w_pend_nxt;

  // Requests seen during ISSUE/FLUSH belong to the wrong path and are dropped.
  assign w_accept   = (r_state == RUN) || (r_state == PEND);
  assign w_pend_src = (r_state == PEND) ? r_pend.src : PCSRC_SEQ;

  redirect_prio_enc u_prio (
    .i_br_req   (br_req_i   & w_accept),
    .i_jalr_req (jalr_req_i & w_accept),
    .i_jal_req  (jal_req_i  & w_accept),
    .i_pend_src (w_pend_src),
    .o_winner   (w_winner),
    .o_we       (w_we),
    .o_conflict (w_conflict)
  );

  // Non-winning operands keep the last issued value so a lost request never leaks out.
  always_comb begin
    w_pend_new.src      = w_winner;
    w_pend_new.imm      = (w_winner == PCSRC_BR)   ? br_imm_i   : r_imm;
    w_pend_new.imm_jal  = (w_winner == PCSRC_JAL)  ? jal_imm_i  : r_imm_jal;
    w_pend_new.jalr_tgt = (w_winner == PCSRC_JALR) ? jalr_tgt_i : r_imm_jalr;
    w_pend_nxt          = w_we ? w_pend_new : r_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_pc_src   <= PCSRC_SEQ;
      r_imm      <= '0;
      r_imm_jal  <= '0;
      r_imm_jalr <= '0;
      r_flush    <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_conflict) r_conflict <= 1'b1;
      case (r_state)
        RUN, PEND: begin
          if (w_we) r_pend <= w_pend_new;
          if (!stall_i && (w_we || r_state == PEND)) begin
            r_state    <= ISSUE;
            r_pc_src   <= w_pend_nxt.src;
            r_imm      <= w_pend_nxt.imm;
            r_imm_jal  <= w_pend_nxt.imm_jal;
            r_imm_jalr <= w_pend_nxt.jalr_tgt;
            r_flush    <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_we) begin
            r_state <= PEND;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          r_pc_src <= PCSRC_SEQ;
          r_pend   <= '0;
          r_cnt    <= FLUSH_LOAD;
          if (FLUSH_CYCLES == 1) begin
            r_state <= RUN;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_cnt <= r_cnt - FLUSH_CNT_W'(1);
          if (r_cnt <= FLUSH_CNT_W'(1)) begin
            r_state <= RUN;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pc_hold_o  = rst | (r_state == PEND) |
                      (((r_state == RUN) || (r_state == FLUSH)) & stall_i);
  assign pc_src_o   = r_pc_src;
  assign imm_o      = r_imm;
  assign imm_jal_o  = r_imm_jal;
  assign imm_jalr_o = r_imm_jalr;
  assign flush_f_o  = r_flush;
  assign busy_o     = r_busy;
  assign conflict_o = r_conflict;

`ifdef FETCH_REDIRECT_PERF_EN
  logic [CNT_W-1:0] r_redirect_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (r_state == ISSUE) r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      if (pc_hold_o)        r_stall_cnt    <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign redirect_cnt_o = r_redirect_cnt;
  assign stall_cnt_o    = r_stall_cnt;
`else
  assign redirect_cnt_o = '0;
  assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: reset, branch, stalled redirect, conflict, reset-in-PEND, counters.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_req_i;
  logic [11:0] br_imm_i;
  logic        jalr_req_i;
  logic [31:0] jalr_tgt_i;
  logic        jal_req_i;
  logic [19:0] jal_imm_i;
  logic [1:0]  pc_src_o;
  logic        pc_hold_o;
  logic [11:0] imm_o;
  logic [19:0] imm_jal_o;
  logic [31:0] imm_jalr_o;
  logic        flush_f_o;
  logic        busy_o;
  logic        conflict_o;
  logic [15:0] redirect_cnt_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .br_req_i(br_req_i), .br_imm_i(br_imm_i),
    .jalr_req_i(jalr_req_i), .jalr_tgt_i(jalr_tgt_i),
    .jal_req_i(jal_req_i), .jal_imm_i(jal_imm_i),
    .pc_src_o(pc_src_o), .pc_hold_o(pc_hold_o),
    .imm_o(imm_o), .imm_jal_o(imm_jal_o), .imm_jalr_o(imm_jalr_o),
    .flush_f_o(flush_f_o), .busy_o(busy_o), .conflict_o(conflict_o),
    .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; br_req_i = 0; jalr_req_i = 0; jal_req_i = 0;
    br_imm_i = '0; jalr_tgt_i = '0; jal_imm_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    checks++;
    if (pc_hold_o !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", pc_hold_o); end
    checks++;
    if ({pc_src_o, flush_f_o, busy_o, conflict_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {pc_src_o, flush_f_o, busy_o, conflict_o});
    end
    checks++;
    if ({imm_o, imm_jal_o, imm_jalr_o} !== 64'h0) begin
      errors++; $display("FAIL reset_imm: got %h want 0", {imm_o, imm_jal_o, imm_jalr_o});
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (pc_hold_o !== 1'b0) begin errors++; $display("FAIL reset_release_hold: got %b want 0", pc_hold_o); end
    tick();
    checks++;
    if ({pc_src_o, pc_hold_o, flush_f_o, busy_o, conflict_o, redirect_cnt_o, stall_cnt_o} !== 38'h0) begin
      errors++; $display("FAIL post_reset_idle: got %h want 0",
                         {pc_src_o, pc_hold_o, flush_f_o, busy_o, conflict_o, redirect_cnt_o, stall_cnt_o});
    end
  endtask

  task automatic test_branch();
    do_reset();
    br_req_i = 1; br_imm_i = 12'h010;
    tick();
    br_req_i = 0; jal_req_i = 1; jal_imm_i = 20'h00055;
    checks++;
    if ({pc_src_o, pc_hold_o, flush_f_o} !== 4'b0101) begin
      errors++; $display("FAIL br_issue: got src=%b hold=%b flush=%b want 01/0/1", pc_src_o, pc_hold_o, flush_f_o);
    end
    checks++;
    if (imm_o !== 12'h010) begin errors++; $display("FAIL br_imm: got %h want 010", imm_o); end
    tick();
    checks++;
    if ({pc_src_o, flush_f_o, busy_o} !== 4'b0011) begin
      errors++; $display("FAIL br_flush2: got src=%b flush=%b busy=%b want 00/1/1", pc_src_o, flush_f_o, busy_o);
    end
    tick();
    jal_req_i = 0;
    checks++;
    if ({flush_f_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL br_flush_end: got flush=%b busy=%b want 0/0", flush_f_o, busy_o);
    end
    tick();
    checks++;
    if ({pc_src_o, busy_o, imm_jal_o} !== 23'h0) begin
      errors++; $display("FAIL br_jal_ignored: got src=%b busy=%b imm_jal=%h want 00/0/0", pc_src_o, busy_o, imm_jal_o);
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    stall_i = 1; jal_req_i = 1; jal_imm_i = 20'h00100;
    tick();
    jal_req_i = 0;
    checks++;
    if ({pc_hold_o, busy_o, pc_src_o} !== 4'b1100) begin
      errors++; $display("FAIL stall_pend_jal: got hold=%b busy=%b src=%b want 1/1/00", pc_hold_o, busy_o, pc_src_o);
    end
    tick();
    jalr_req_i = 1; jalr_tgt_i = 32'h0001_0040;
    tick();
    jalr_req_i = 0;
    checks++;
    if ({pc_hold_o, pc_src_o, flush_f_o} !== 4'b1000) begin
      errors++; $display("FAIL stall_pend_jalr: got hold=%b src=%b flush=%b want 1/00/0", pc_hold_o, pc_src_o, flush_f_o);
    end
    stall_i = 0;
    tick();
    checks++;
    if ({pc_src_o, pc_hold_o, flush_f_o} !== 4'b1101) begin
      errors++; $display("FAIL stall_issue: got src=%b hold=%b flush=%b want 11/0/1", pc_src_o, pc_hold_o, flush_f_o);
    end
    checks++;
    if (imm_jalr_o !== 32'h0001_0040 || imm_jal_o !== 20'h0) begin
      errors++; $display("FAIL stall_imms: got jalr=%h jal=%h want 00010040/00000", imm_jalr_o, imm_jal_o);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pc_src_o, busy_o} !== 3'b000) begin
        errors++; $display("FAIL stall_jal_lost: got src=%b busy=%b want 00/0", pc_src_o, busy_o);
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    br_req_i = 1; br_imm_i = 12'h020; jalr_req_i = 1; jalr_tgt_i = 32'hDEAD_BEE0;
    tick();
    br_req_i = 0; jalr_req_i = 0; stall_i = 1;
    checks++;
    if ({pc_src_o, conflict_o, imm_o} !== {2'b01, 1'b1, 12'h020}) begin
      errors++; $display("FAIL conflict_issue: got src=%b conflict=%b imm=%h want 01/1/020", pc_src_o, conflict_o, imm_o);
    end
    checks++;
    if ({pc_hold_o, imm_jalr_o} !== 33'h0) begin
      errors++; $display("FAIL issue_ignores_stall: got hold=%b jalr=%h want 0/0", pc_hold_o, imm_jalr_o);
    end
    tick();
    checks++;
    if ({pc_hold_o, flush_f_o} !== 2'b11) begin
      errors++; $display("FAIL flush_hold_follows_stall: got hold=%b flush=%b want 1/1", pc_hold_o, flush_f_o);
    end
    stall_i = 0;
    repeat (4) tick();
    checks++;
    if (conflict_o !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b want 1", conflict_o); end
    do_reset();
    checks++;
    if (conflict_o !== 1'b0) begin errors++; $display("FAIL conflict_clear: got %b want 0", conflict_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    jal_req_i = 1; jal_imm_i = 20'hABCDE;
    tick();
    jal_req_i = 0;
    checks++;
    if ({pc_src_o, imm_jal_o} !== {2'b10, 20'hABCDE}) begin
      errors++; $display("FAIL b2b_jal: got src=%b imm_jal=%h want 10/abcde", pc_src_o, imm_jal_o);
    end
    tick();
    tick();
    br_req_i = 1; br_imm_i = 12'h7FF;
    tick();
    br_req_i = 0;
    checks++;
    if ({pc_src_o, imm_o, imm_jal_o} !== {2'b01, 12'h7FF, 20'hABCDE}) begin
      errors++; $display("FAIL b2b_br: got src=%b imm=%h imm_jal=%h want 01/7ff/abcde", pc_src_o, imm_o, imm_jal_o);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    stall_i = 1; br_req_i = 1; br_imm_i = 12'h123;
    tick();
    br_req_i = 0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL pend_busy: got %b want 1", busy_o); end
    rst = 1; stall_i = 0;
    tick();
    rst = 0;
    checks++;
    if ({busy_o, pc_src_o} !== 3'b000) begin
      errors++; $display("FAIL pend_reset: got busy=%b src=%b want 0/00", busy_o, pc_src_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({pc_src_o, flush_f_o, imm_o} !== 15'h0) begin
        errors++; $display("FAIL pend_no_issue: got src=%b flush=%b imm=%h want 00/0/000", pc_src_o, flush_f_o, imm_o);
      end
    end
  endtask

  task automatic test_perf_counters();
    logic [15:0] exp_redir;
    logic [15:0] exp_stall;
`ifdef FETCH_REDIRECT_PERF_EN
    exp_redir = 16'd3;
    exp_stall = 16'd5;
`else
    exp_redir = 16'd0;
    exp_stall = 16'd0;
`endif
    do_reset();
    stall_i = 1;
    repeat (5) tick();
    stall_i = 0;
    for (int i = 0; i < 3; i++) begin
      br_req_i = 1; br_imm_i = 12'(i + 1);
      tick();
      br_req_i = 0;
      tick();
      tick();
    end
    tick();
    checks++;
    if (redirect_cnt_o !== exp_redir) begin
      errors++; $display("FAIL perf_redirect: got %0d want %0d", redirect_cnt_o, exp_redir);
    end
    checks++;
    if (stall_cnt_o !== exp_stall) begin
      errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_branch();
    test_stall_redirect();
    test_conflict();
    test_back_to_back();
    test_reset_in_pend();
    test_perf_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
